max_aggregator: RTL and testbench



---
 rtl/max_aggregator.sv | 132 +++++++++++++
 tb/tb_max_aggregator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/max_aggregator.sv
// max_aggregator
//   Per-node channel-wise signed max reduction of a neighbor message stream.
//   Each completed node vector is presented downstream as a fixed-length
//   valid window (HOLD_CYCLES) followed by a forced low gap (GAP_CYCLES).
//   While a window is running, the next node keeps accumulating. If that
//   node completes before the window and gap end, it is parked as pending
//   and input is stalled until it is loaded into the output register.
//
// Ports
//   clk        clock
//   rstn       synchronous active-low reset
//   msg_pack   neighbor message, channel c at [(c+1)*B_WIDTH-1 -: B_WIDTH], signed
//   msg_valid  message beat valid
//   msg_last   beat is the final neighbor of the current node
//   msg_ready  beat accepted when msg_valid && msg_ready
//   aggr_pack  aggregated node vector, same packing as msg_pack
//   aggr_valid valid window to the downstream stage
module max_aggregator #(
  parameter int unsigned OUT_C       = 32,
  parameter int unsigned B_WIDTH     = 16,
  parameter int unsigned HOLD_CYCLES = 5,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [OUT_C*B_WIDTH-1:0]   msg_pack,
  input  logic                       msg_valid,
  input  logic                       msg_last,
  output logic                       msg_ready,
  output logic [OUT_C*B_WIDTH-1:0]   aggr_pack,
  output logic                       aggr_valid
);

  localparam int unsigned PACK_W  = OUT_C * B_WIDTH;
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Most negative value in every channel: identity element for max.
  localparam logic [B_WIDTH-1:0] MIN_CH   = {1'b1, {(B_WIDTH-1){1'b0}}};
  localparam logic [PACK_W-1:0]  MIN_PACK = {OUT_C{MIN_CH}};

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_HOLD = 2'd1,
    O_GAP  = 2'd2
  } ostate_t;

  ostate_t             state;
  logic [CNT_W-1:0]    cnt;
  logic                pending;
  logic [PACK_W-1:0]   acc;
  logic [PACK_W-1:0]   comb_pack;
  logic                beat_accept;

  // Stall input only while a completed node waits for the output register.
  assign msg_ready   = ~pending;
  assign beat_accept = msg_valid & ~pending;

  // Channel-wise signed max of accumulator and incoming beat; ties keep acc.
  always_comb begin
    comb_pack = acc;
    for (int c = 0; c < int'(OUT_C); c++) begin
      if ($signed(msg_pack[c*B_WIDTH +: B_WIDTH]) > $signed(acc[c*B_WIDTH +: B_WIDTH])) begin
        comb_pack[c*B_WIDTH +: B_WIDTH] = msg_pack[c*B_WIDTH +: B_WIDTH];
      end
    end
  end

  // Output window FSM, accumulator and pending node handling.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= O_IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      acc        <= MIN_PACK;
      aggr_pack  <= '0;
      aggr_valid <= 1'b0;
    end else begin
      case (state)
        O_IDLE: begin
          if (pending) begin
            aggr_pack  <= acc;
            acc        <= MIN_PACK;
            pending    <= 1'b0;
            state      <= O_HOLD;
            cnt        <= '0;
            aggr_valid <= 1'b1;
          end
        end
        O_HOLD: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state      <= O_GAP;
            cnt        <= '0;
            aggr_valid <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        O_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            state <= O_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state      <= O_IDLE;
          cnt        <= '0;
          aggr_valid <= 1'b0;
        end
      endcase

      // An accepted beat never coincides with a pending load (ready is low then).
      if (beat_accept) begin
        if (!msg_last) begin
          acc <= comb_pack;
        end else if (state == O_IDLE) begin
          aggr_pack  <= comb_pack;
          acc        <= MIN_PACK;
          state      <= O_HOLD;
          cnt        <= '0;
          aggr_valid <= 1'b1;
        end else begin
          acc     <= comb_pack;
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_max_aggregator.sv
// Directed testbench for max_aggregator with hand-computed expected vectors.
module tb_max_aggregator;

  localparam int unsigned OUT_C       = 32;
  localparam int unsigned B_WIDTH     = 16;
  localparam int unsigned HOLD_CYCLES = 5;
  localparam int unsigned GAP_CYCLES  = 1;
  localparam int unsigned PACK_W      = OUT_C * B_WIDTH;

  logic              clk = 1'b0;
  logic              rstn;
  logic [PACK_W-1:0] msg_pack;
  logic              msg_valid;
  logic              msg_last;
  logic              msg_ready;
  logic [PACK_W-1:0] aggr_pack;
  logic              aggr_valid;

  int checks = 0;
  int errors = 0;

  max_aggregator #(
    .OUT_C      (OUT_C),
    .B_WIDTH    (B_WIDTH),
    .HOLD_CYCLES(HOLD_CYCLES),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .msg_pack  (msg_pack),
    .msg_valid (msg_valid),
    .msg_last  (msg_last),
    .msg_ready (msg_ready),
    .aggr_pack (aggr_pack),
    .aggr_valid(aggr_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PACK_W-1:0] obs, input logic [PACK_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PACK_W-1:0] set_ch(input logic [PACK_W-1:0] p, input int c,
                                               input int v);
    logic [PACK_W-1:0] r;
    r = p;
    r[c*B_WIDTH +: B_WIDTH] = B_WIDTH'(v);
    return r;
  endfunction

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [PACK_W-1:0] p, input logic last);
    msg_pack  = p;
    msg_valid = 1'b1;
    msg_last  = last;
    tick();
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_valid(input string tag, input logic exp);
    check(tag, PACK_W'(aggr_valid), PACK_W'(exp));
  endtask

  task automatic check_ready(input string tag, input logic exp);
    check(tag, PACK_W'(msg_ready), PACK_W'(exp));
  endtask

  logic [PACK_W-1:0] p, exp_a, exp_b, garbage;
  logic exp_v[5];

  initial begin
    rstn      = 1'b0;
    msg_pack  = '0;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    tick();
    tick();

    // Reset state
    check_ready("rst_ready", 1'b1);
    check_valid("rst_valid", 1'b0);
    check("rst_pack", aggr_pack, '0);
    rstn = 1'b1;
    idle(1);

    // Three beats on ch0: -5, 3, -7 -> 3; window of exactly 5 cycles
    beat(set_ch('0, 0, -5), 1'b0);
    beat(set_ch('0, 0, 3), 1'b0);
    check_valid("t1_pre_last", 1'b0);
    beat(set_ch('0, 0, -7), 1'b1);
    exp_a = set_ch('0, 0, 3);
    for (int i = 0; i < int'(HOLD_CYCLES); i++) begin
      check_valid($sformatf("t1_win%0d", i), 1'b1);
      check($sformatf("t1_pack%0d", i), aggr_pack, exp_a);
      if (i != int'(HOLD_CYCLES) - 1) idle(1);
    end
    idle(1);
    check_valid("t1_after", 1'b0);
    idle(2);

    // Single-beat node with extreme negative and -1
    p = set_ch(set_ch('0, 0, -32768), 1, -1);
    beat(p, 1'b1);
    check_valid("t2_valid", 1'b1);
    check("t2_pack", aggr_pack, p);
    idle(8);

    // Node A, then node B completes during A's window -> pending
    exp_a = set_ch('0, 0, 100);
    beat(exp_a, 1'b1);
    check("t3_a_w1", aggr_pack, exp_a);
    beat(set_ch(set_ch('0, 0, 7), 2, -3), 1'b0);
    check("t3_a_w2", aggr_pack, exp_a);
    check_ready("t3_ready_mid", 1'b1);
    beat(set_ch(set_ch('0, 0, -2), 2, 50), 1'b1);
    check("t3_a_w3", aggr_pack, exp_a);
    check_ready("t3_ready_low", 1'b0);
    exp_b = set_ch(set_ch('0, 0, 7), 2, 50);
    exp_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check_valid($sformatf("t3_seq%0d", i), exp_v[i]);
      if (i < 2) check($sformatf("t3_a_w%0d", i + 4), aggr_pack, exp_a);
      if (i == 3) check_ready("t3_ready_idle", 1'b0);
    end
    check("t3_b_pack", aggr_pack, exp_b);
    check_ready("t3_ready_back", 1'b1);
    idle(8);

    // msg_valid toggling: unaccepted cycles carry junk that must be ignored
    garbage = set_ch('0, 0, 1000);
    for (int i = 0; i < 4; i++) begin
      int v;
      v = (i == 0) ? 1 : (i == 1) ? 9 : (i == 2) ? 4 : 9;
      beat(set_ch('0, 0, v), (i == 3) ? 1'b1 : 1'b0);
      if (i != 3) begin
        msg_pack  = garbage;
        msg_last  = 1'b1;
        msg_valid = 1'b0;
        tick();
        msg_last  = 1'b0;
        check_valid($sformatf("t4_gap%0d", i), 1'b0);
      end
    end
    check_valid("t4_valid", 1'b1);
    check("t4_pack", aggr_pack, set_ch('0, 0, 9));
    idle(8);

    // Reset during a window with two beats of the next node accumulated
    beat(set_ch('0, 0, 55), 1'b1);
    beat(set_ch(set_ch('0, 0, 200), 1, 300), 1'b0);
    beat(set_ch('0, 0, 150), 1'b0);
    check_valid("t5_pre_rst", 1'b1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check_valid("t5_rst_valid", 1'b0);
    check("t5_rst_pack", aggr_pack, '0);
    check_ready("t5_rst_ready", 1'b1);
    p = set_ch(set_ch('0, 0, -10), 1, -20);
    beat(p, 1'b1);
    check_valid("t5_new_valid", 1'b1);
    check("t5_new_pack", aggr_pack, p);
    idle(8);

    // All channels, 8 beats: channel c peaks at c*100-1500 on beat c%8
    exp_a = '0;
    for (int c = 0; c < int'(OUT_C); c++) exp_a = set_ch(exp_a, c, c*100 - 1500);
    for (int b = 0; b < 8; b++) begin
      p = '0;
      for (int c = 0; c < int'(OUT_C); c++)
        p = set_ch(p, c, (b == c % 8) ? c*100 - 1500 : c*100 - 1600 - b);
      beat(p, (b == 7) ? 1'b1 : 1'b0);
    end
    check_valid("t6_valid", 1'b1);
    check("t6_pack", aggr_pack, exp_a);
    for (int c = 0; c < int'(OUT_C); c += 9)
      check($sformatf("t6_ch%0d", c), PACK_W'(aggr_pack[c*B_WIDTH +: B_WIDTH]),
            PACK_W'(exp_a[c*B_WIDTH +: B_WIDTH]));
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
